mem_store_buffer: RTL

//  MEM-stage store buffer directly upstream of data memory (DM). Accepts load/store

---
 rtl/mem_store_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: FIFO of pending stores draining to data memory one per idle
// DM cycle, with youngest-entry store-to-load forwarding and partial-overlap stalls.
module mem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     req_ready,
    output logic [31:0]              ld_data,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wdata,
    output logic                     dm_write,
    input  logic [31:0]              dm_rdata,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [ADDR_W-1:0] w_ld_addr;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_hit;
    logic [PW-1:0]     w_hit_idx;
    logic              w_hit_exact;
    logic              w_partial;
    logic              w_not_full;
    logic              w_push;
    logic              w_drain;

    assign w_ld_addr  = req_addr[ADDR_W-1:0];
    assign w_is_load  = req_valid & ~req_write;
    assign w_is_store = req_valid & req_write;
    assign w_not_full = (r_count < CW'(DEPTH));

    // Scan oldest to youngest so the last overlapping entry found is the youngest one.
    always_comb begin
        logic [PW-1:0]     idx;
        logic [ADDR_W-1:0] d_ab;
        logic [ADDR_W-1:0] d_ba;
        w_hit     = 1'b0;
        w_hit_idx = '0;
        idx       = '0;
        d_ab      = '0;
        d_ba      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx  = r_head + PW'(i);
            d_ab = r_addr[idx] - w_ld_addr;
            d_ba = w_ld_addr - r_addr[idx];
            if ((CW'(i) < r_count) && ((d_ab < ADDR_W'(4)) || (d_ba < ADDR_W'(4)))) begin
                w_hit     = 1'b1;
                w_hit_idx = idx;
            end
        end
        w_hit_exact = w_hit && (r_addr[w_hit_idx] == w_ld_addr);
    end

    assign w_partial = w_is_load & w_hit & ~w_hit_exact;
    // A stalled partial-overlap load hands the DM port to the drain to avoid deadlock.
    assign w_drain   = (r_count != '0) & (~w_is_load | w_partial);
    assign w_push    = w_is_store & w_not_full;

    always_comb begin
        req_ready = 1'b1;
        ld_data   = '0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_write  = 1'b0;
        if (rst_n) begin
            if (w_is_store) begin
                req_ready = w_not_full;
            end else if (w_is_load) begin
                req_ready = ~w_partial;
            end
            if (w_drain) begin
                dm_write = 1'b1;
                dm_addr  = 32'(r_addr[r_head]);
                dm_wdata = r_data[r_head];
            end else if (w_is_load) begin
                dm_addr = req_addr;
                ld_data = w_hit ? r_data[w_hit_idx] : dm_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= w_ld_addr;
                r_data[r_tail] <= req_wdata;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign sb_count = r_count;
    assign sb_empty = (r_count == '0);

endmodule
